// File: rtl/proc_gen_pkg.sv
// proc_gen_pkg: shared constants for the proc_gen multi-cycle processor.
//   - opcode field width and opcode values
//   - step encoding T0..T3 (drives Tstep_Q)
//   - bit positions of Z and C inside the 2-bit Flags output ({Z,C})
//   - is_alu_op(): opcodes that take the four-step A/G path
package proc_gen_pkg;

  localparam int OPC_W = 4;

  localparam logic [OPC_W-1:0] OP_MV   = 4'd0;
  localparam logic [OPC_W-1:0] OP_MVI  = 4'd1;
  localparam logic [OPC_W-1:0] OP_ADD  = 4'd2;
  localparam logic [OPC_W-1:0] OP_SUB  = 4'd3;
  localparam logic [OPC_W-1:0] OP_ADDI = 4'd4;
  localparam logic [OPC_W-1:0] OP_SUBI = 4'd5;
  localparam logic [OPC_W-1:0] OP_AND  = 4'd6;
  localparam logic [OPC_W-1:0] OP_OR   = 4'd7;
  localparam logic [OPC_W-1:0] OP_XOR  = 4'd8;
  localparam logic [OPC_W-1:0] OP_SHL  = 4'd9;
  localparam logic [OPC_W-1:0] OP_SHR  = 4'd10;
  localparam logic [OPC_W-1:0] OP_CMP  = 4'd11;
  localparam logic [OPC_W-1:0] OP_MVNZ = 4'd12;

  localparam logic [1:0] T0 = 2'd0;
  localparam logic [1:0] T1 = 2'd1;
  localparam logic [1:0] T2 = 2'd2;
  localparam logic [1:0] T3 = 2'd3;

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;

  function automatic logic is_alu_op(input logic [OPC_W-1:0] op);
    return (op >= OP_ADD) && (op <= OP_CMP);
  endfunction

endpackage

// File: rtl/proc_gen_if.sv
// proc_gen_if: instruction/bus interface between the processor and the lab top.
//   DIN      : instruction word (T0) or immediate (T1 mvi, T2 addi/subi)
//   Run      : start request, sampled only in T0
//   Done     : high during the final step of each instruction
//   BusWires : shared datapath bus
//   IR       : instruction register
//   Flags    : {Z,C}
//   Tstep_Q  : current step T0..T3
// master = instruction source (lab top / bench), slave = processor.
interface proc_gen_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] DIN;
  logic              Run;
  logic              Done;
  logic [DATA_W-1:0] BusWires;
  logic [DATA_W-1:0] IR;
  logic [1:0]        Flags;
  logic [1:0]        Tstep_Q;

  modport master (
    output DIN, Run,
    input  Done, BusWires, IR, Flags, Tstep_Q
  );

  modport slave (
    input  DIN, Run,
    output Done, BusWires, IR, Flags, Tstep_Q
  );
endinterface

// File: rtl/proc_gen_alu.sv
// proc_gen_alu: combinational ALU for proc_gen.
//   a, b     : operands (a = staged Rx, b = bus value)
//   op       : opcode from IR
//   result   : DATA_W-bit truncated result
//   z        : result == 0
//   c        : carry (add/addi) or unsigned borrow (sub/subi/cmp)
//   c_valid  : op is one that writes C; logic ops and shifts leave C alone
module proc_gen_alu
  import proc_gen_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [OPC_W-1:0]  op,
  output logic [DATA_W-1:0] result,
  output logic              z,
  output logic              c,
  output logic              c_valid
);

  localparam int SH_W = $clog2(DATA_W);

  logic [DATA_W:0] w_sum;
  logic [DATA_W:0] w_diff;
  logic [SH_W-1:0] w_sh;

  // The extra top bit of w_diff is the unsigned borrow, i.e. a < b.
  assign w_sum  = {1'b0, a} + {1'b0, b};
  assign w_diff = {1'b0, a} - {1'b0, b};
  assign w_sh   = b[SH_W-1:0];

  always_comb begin
    result  = b;
    c       = 1'b0;
    c_valid = 1'b0;
    case (op)
      OP_ADD, OP_ADDI: begin
        result  = w_sum[DATA_W-1:0];
        c       = w_sum[DATA_W];
        c_valid = 1'b1;
      end
      OP_SUB, OP_SUBI, OP_CMP: begin
        result  = w_diff[DATA_W-1:0];
        c       = w_diff[DATA_W];
        c_valid = 1'b1;
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_SHL:  result = a << w_sh;
      OP_SHR:  result = a >> w_sh;
      default: result = b;
    endcase
    z = (result == '0);
  end

endmodule

// File: rtl/proc_gen.sv
// proc_gen: parametrised multi-cycle single-bus processor.
//   Clock  : rising-edge clock
//   Resetn : asynchronous active-low reset; clears step, IR, A, G, flags, registers
//   pif    : proc_gen_if.slave (DIN, Run in; Done, BusWires, IR, Flags, Tstep_Q out)
// Instruction word: opcode = IR[DATA_W-1 -: 4], X below it, Y below X (REG_AW bits
// each); remaining low bits are ignored. DATA_W must be >= 4 + 2*REG_AW.
// mv/mvi/mvnz/nop finish in T1; ALU ops (add..cmp) run T1 A<-Rx, T2 G<-ALU,
// T3 Rx<-G plus flag update.
module proc_gen
  import proc_gen_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8
) (
  input  logic        Clock,
  input  logic        Resetn,
  proc_gen_if.slave   pif
);

  localparam int REG_AW = $clog2(NUM_REGS);

  logic [1:0]        r_step;
  logic [DATA_W-1:0] r_ir;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_g;
  logic              r_gz;
  logic              r_gc;
  logic [1:0]        r_flags;

  logic [NUM_REGS-1:0][DATA_W-1:0] w_regs;

  logic [OPC_W-1:0]  w_opc;
  logic [REG_AW-1:0] w_x;
  logic [REG_AW-1:0] w_y;
  logic              w_alu;

  logic [1:0]        w_step_nxt;
  logic [NUM_REGS-1:0] w_rin;
  logic [NUM_REGS-1:0] w_rout;
  logic              w_dinout;
  logic              w_gout;
  logic              w_ain;
  logic              w_gin;
  logic              w_flag_we;
  logic              w_done;
  logic [DATA_W-1:0] w_bus;

  logic [DATA_W-1:0] w_alu_res;
  logic              w_alu_z;
  logic              w_alu_c;
  logic              w_alu_cv;

  assign w_opc = r_ir[DATA_W-1 -: OPC_W];
  assign w_x   = r_ir[DATA_W-OPC_W-1 -: REG_AW];
  assign w_y   = r_ir[DATA_W-OPC_W-REG_AW-1 -: REG_AW];
  assign w_alu = is_alu_op(w_opc);

  // Step sequencer and bus/register enables
  always_comb begin
    w_step_nxt = r_step;
    w_rin      = '0;
    w_rout     = '0;
    w_dinout   = 1'b0;
    w_gout     = 1'b0;
    w_ain      = 1'b0;
    w_gin      = 1'b0;
    w_flag_we  = 1'b0;
    w_done     = 1'b0;
    case (r_step)
      T0: begin
        if (pif.Run) w_step_nxt = T1;
      end
      T1: begin
        if (w_alu) begin
          w_rout[w_x] = 1'b1;
          w_ain       = 1'b1;
          w_step_nxt  = T2;
        end else begin
          w_done     = 1'b1;
          w_step_nxt = T0;
          case (w_opc)
            OP_MV: begin
              w_rout[w_y] = 1'b1;
              w_rin[w_x]  = 1'b1;
            end
            OP_MVI: begin
              w_dinout   = 1'b1;
              w_rin[w_x] = 1'b1;
            end
            OP_MVNZ: begin
              // Ry is placed on the bus either way; only the write is conditional.
              w_rout[w_y] = 1'b1;
              if (!r_flags[FLAG_Z]) w_rin[w_x] = 1'b1;
            end
            default: ;
          endcase
        end
      end
      T2: begin
        if ((w_opc == OP_ADDI) || (w_opc == OP_SUBI)) w_dinout = 1'b1;
        else                                           w_rout[w_y] = 1'b1;
        w_gin      = 1'b1;
        w_step_nxt = T3;
      end
      default: begin
        w_gout     = 1'b1;
        if (w_opc != OP_CMP) w_rin[w_x] = 1'b1;
        w_flag_we  = 1'b1;
        w_done     = 1'b1;
        w_step_nxt = T0;
      end
    endcase
  end

  // Bus mux: DINout > Rout (lowest index) > Gout > DIN default.
  // Scanning registers downward lets the lowest asserted index win.
  always_comb begin
    w_bus = pif.DIN;
    if (w_gout) w_bus = r_g;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (w_rout[i]) w_bus = w_regs[i];
    end
    if (w_dinout) w_bus = pif.DIN;
  end

  proc_gen_alu #(.DATA_W(DATA_W)) u_alu (
    .a       (r_a),
    .b       (w_bus),
    .op      (w_opc),
    .result  (w_alu_res),
    .z       (w_alu_z),
    .c       (w_alu_c),
    .c_valid (w_alu_cv)
  );

  // Control and staging registers
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_step  <= T0;
      r_ir    <= '0;
      r_a     <= '0;
      r_g     <= '0;
      r_gz    <= 1'b0;
      r_gc    <= 1'b0;
      r_flags <= 2'b00;
    end else begin
      r_step <= w_step_nxt;
      if ((r_step == T0) && pif.Run) r_ir <= pif.DIN;
      if (w_ain) r_a <= w_bus;
      // Z/C are captured with G in T2 and committed in T3 alongside the Rx write,
      // since the bus no longer carries the ALU operand by then.
      if (w_gin) begin
        r_g  <= w_alu_res;
        r_gz <= w_alu_z;
        r_gc <= w_alu_c;
      end
      if (w_flag_we) begin
        r_flags[FLAG_Z] <= r_gz;
        if (w_alu_cv) r_flags[FLAG_C] <= r_gc;
      end
    end
  end

  // General register file
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    logic [DATA_W-1:0] r_q;
    always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn)        r_q <= '0;
      else if (w_rin[gi]) r_q <= w_bus;
    end
    assign w_regs[gi] = r_q;
  end

  assign pif.Done     = w_done;
  assign pif.BusWires = w_bus;
  assign pif.IR       = r_ir;
  assign pif.Flags    = r_flags;
  assign pif.Tstep_Q  = r_step;

endmodule
